// File: rtl/ccc_seq_pkg.sv
// ccc_seq_pkg: FSM state encodings and default timing for the CCC lock sequencer
package ccc_seq_pkg;
    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] QUALIFY   = 2'd1;
    localparam logic [1:0] RELEASE   = 2'd2;
    localparam logic [1:0] RUN       = 2'd3;
    localparam int DEF_NUM_DOMAINS         = 3;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_STAGGER_CYCLES      = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_LOSS_CNT_W          = 8;
endpackage

// File: rtl/lock_sync.sv
// lock_sync: 2-flop synchroniser for the CCC lock, cleared by the fabric reset
module lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk) begin
        if (!rst_n) {q, meta} <= 2'b00;
        else        {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/ccc_lock_sequencer.sv
// ccc_lock_sequencer: qualifies CCC lock, then releases fabric domain resets in staggered order
module ccc_lock_sequencer
    import ccc_seq_pkg::*;
#(
    parameter int NUM_DOMAINS         = DEF_NUM_DOMAINS,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int STAGGER_CYCLES      = DEF_STAGGER_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOSS_CNT_W          = DEF_LOSS_CNT_W
) (
    input  logic                   fab_clk,
    input  logic                   m2f_reset_n,
    input  logic                   fab_lock,
    input  logic                   restart,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   ready,
    output logic                   lock_timeout,
    output logic [LOSS_CNT_W-1:0]  loss_cnt,
    output logic [1:0]             state
);
    localparam int MAXC = LOCK_STABLE_CYCLES > STAGGER_CYCLES ? LOCK_STABLE_CYCLES : STAGGER_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam logic [NUM_DOMAINS-1:0] FIRST = NUM_DOMAINS'(1);
    logic                   lock_s;
    logic [CW-1:0]          cnt;
    logic [TW-1:0]          tcnt;
    logic [NUM_DOMAINS-1:0] rst_shift;
    lock_sync u_sync (
        .clk  (fab_clk),
        .rst_n(m2f_reset_n),
        .d    (fab_lock),
        .q    (lock_s)
    );
    // Next release pattern: one more domain out of reset, lowest bits first
    assign rst_shift = (domain_rst_n << 1) | FIRST;
    always_ff @(posedge fab_clk) begin
        if (!m2f_reset_n || restart) begin
            state        <= WAIT_LOCK;
            cnt          <= '0;
            tcnt         <= '0;
            domain_rst_n <= '0;
            ready        <= 1'b0;
            lock_timeout <= 1'b0;
            if (!m2f_reset_n) loss_cnt <= '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    domain_rst_n <= '0;
                    ready        <= 1'b0;
                    if (lock_s) begin
                        state <= QUALIFY;
                        cnt   <= '0;
                        tcnt  <= '0;
                    end else if (tcnt == TW'(LOCK_TIMEOUT_CYCLES - 1)) lock_timeout <= 1'b1;
                    else tcnt <= tcnt + 1'b1;
                end
                QUALIFY: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
                        cnt          <= '0;
                        domain_rst_n <= FIRST;
                        ready        <= &FIRST;
                        state        <= (&FIRST) ? RUN : RELEASE;
                    end else cnt <= cnt + 1'b1;
                end
                default: begin
                    // RELEASE and RUN share lock-loss handling
                    if (!lock_s) begin
                        state        <= WAIT_LOCK;
                        cnt          <= '0;
                        domain_rst_n <= '0;
                        ready        <= 1'b0;
                        if (!(&loss_cnt)) loss_cnt <= loss_cnt + 1'b1;
                    end else if (state == RELEASE) begin
                        if (cnt == CW'(STAGGER_CYCLES - 1)) begin
                            cnt          <= '0;
                            domain_rst_n <= rst_shift;
                            if (&rst_shift) begin
                                state <= RUN;
                                ready <= 1'b1;
                            end
                        end else cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
